// File: rtl/seg7_pkg.sv
// seg7_pkg: character codes and active-low segment patterns (seg[0:6] = a..g)
// shared by the 7-segment scan driver and its decoder.
package seg7_pkg;

    localparam logic [3:0] CODE_R     = 4'hA;
    localparam logic [3:0] CODE_DASH  = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [0:6] SEG_OFF  = 7'b1111111;
    localparam logic [0:6] SEG_0    = 7'b0000001;
    localparam logic [0:6] SEG_1    = 7'b1001111;
    localparam logic [0:6] SEG_2    = 7'b0010010;
    localparam logic [0:6] SEG_3    = 7'b0000110;
    localparam logic [0:6] SEG_4    = 7'b1001100;
    localparam logic [0:6] SEG_5    = 7'b0100100;
    localparam logic [0:6] SEG_6    = 7'b0100000;
    localparam logic [0:6] SEG_7    = 7'b0001111;
    localparam logic [0:6] SEG_8    = 7'b0000000;
    localparam logic [0:6] SEG_9    = 7'b0001100;
    localparam logic [0:6] SEG_R    = 7'b1111010;
    localparam logic [0:6] SEG_DASH = 7'b1111110;

    // Codes C..F carry no glyph and count as blank for leading-zero purposes.
    function automatic logic is_blank_code(input logic [3:0] code);
        return (code >= 4'hC);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational character-code to active-low segment decoder.
// A high 'blank' forces every segment off regardless of the code.
module seg7_decode (
    input  logic [3:0] code,
    input  logic       blank,
    output logic [0:6] seg
);
    import seg7_pkg::*;

    // Glyph lookup; anything without a glyph stays dark.
    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (code)
                4'h0:      seg = SEG_0;
                4'h1:      seg = SEG_1;
                4'h2:      seg = SEG_2;
                4'h3:      seg = SEG_3;
                4'h4:      seg = SEG_4;
                4'h5:      seg = SEG_5;
                4'h6:      seg = SEG_6;
                4'h7:      seg = SEG_7;
                4'h8:      seg = SEG_8;
                4'h9:      seg = SEG_9;
                CODE_R:    seg = SEG_R;
                CODE_DASH: seg = SEG_DASH;
                default:   seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver.
// Codes are double-buffered (pending -> active at frame wrap) so a frame never
// tears; each digit slot opens with one dead-time cycle. Optional blinking is
// enabled by defining SEG7_SCAN_BLINK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000
`ifdef SEG7_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] codes,
    input  logic                    blank_lz,
`ifdef SEG7_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [0:6]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_tick
);
    import seg7_pkg::*;

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]             pre;
    logic [IDX_W-1:0]             idx;
    logic [NUM_DIGITS-1:0][3:0]   pend_codes;
    logic [NUM_DIGITS-1:0][3:0]   act_codes;
    logic                         slot_end;
    logic                         frame_wrap;
    logic [NUM_DIGITS-1:0]        lz_blank;
    logic                         lead;
    logic [NUM_DIGITS-1:0]        slot_en;
    logic [3:0]                   cur_code;
    logic                         cur_blank;
    logic [0:6]                   cur_seg;

    assign slot_end   = (pre == PRE_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    // Prescaler counts clocks within a slot; the scan index steps at slot end.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
            idx <= '0;
        end else if (slot_end) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Double buffer: loads land in pending; active follows only at frame wrap,
    // and a load on the wrap edge itself goes straight through.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_codes <= {NUM_DIGITS{CODE_BLANK}};
            act_codes  <= {NUM_DIGITS{CODE_BLANK}};
        end else begin
            if (load) begin
                pend_codes <= codes;
            end
            if (frame_wrap) begin
                act_codes <= load ? codes : pend_codes;
            end
        end
    end

    // Leading-zero mask: a zero is blanked while everything above it is zero or blank.
    always_comb begin
        lz_blank = '0;
        lead     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_blank[i] = lead && (act_codes[i] == 4'h0);
            lead        = lead && ((act_codes[i] == 4'h0) || is_blank_code(act_codes[i]));
        end
    end

    // One-cold enable for the digit currently being scanned.
    always_comb begin
        slot_en      = '1;
        slot_en[idx] = 1'b0;
    end

    assign cur_code = act_codes[idx];

`ifdef SEG7_SCAN_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0]       frame_cnt;
    logic                  blink_on;
    logic [NUM_DIGITS-1:0] pend_mask;
    logic [NUM_DIGITS-1:0] act_mask;

    // Blink mask is buffered like the codes; phase flips every BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            pend_mask <= '0;
            act_mask  <= '0;
        end else begin
            if (load) begin
                pend_mask <= blink_mask;
            end
            if (frame_wrap) begin
                act_mask <= load ? blink_mask : pend_mask;
                if (frame_cnt == BF_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign cur_blank = (blank_lz && lz_blank[idx]) || (!blink_on && act_mask[idx]);
`else
    assign cur_blank = blank_lz && lz_blank[idx];
`endif

    seg7_decode u_decode (
        .code  (cur_code),
        .blank (cur_blank),
        .seg   (cur_seg)
    );

    // Registered pins: dead time on the first cycle of each slot, glyph otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dig_en     <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (pre == '0) begin
                seg    <= SEG_OFF;
                dig_en <= '1;
            end else begin
                seg    <= cur_seg;
                dig_en <= slot_en;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: behavioural model compared every cycle, plus literal
// spot checks of glyphs, scan sequence, frame rate and reset behaviour.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int F  = ND * SD;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        blank_lz;
    logic [15:0] codes;
    logic [0:6]  seg;
    logic [3:0]  dig_en;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .codes      (codes),
        .blank_lz   (blank_lz),
`ifdef SEG7_SCAN_BLINK_EN
        .blink_mask (4'b0000),
`endif
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [0:6] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0001100;
            4'hA: return 7'b1111010;
            4'hB: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit lz_off(input logic [15:0] a, input int i);
        logic [3:0] c;
        if (i == 0) return 1'b0;
        if (a[4*i +: 4] != 4'h0) return 1'b0;
        for (int j = i + 1; j < ND; j++) begin
            c = a[4*j +: 4];
            if (c != 4'h0 && c < 4'hC) return 1'b0;
        end
        return 1'b1;
    endfunction

    int          k;
    int          mp;
    int          md;
    logic [15:0] m_pend;
    logic [15:0] m_act;
    logic [0:6]  e_seg;
    logic [3:0]  e_en;
    logic        e_tick;
    bit          m_valid = 1'b0;

    // Model: position within the frame is the edge count since reset modulo F.
    always @(posedge clk) begin
        if (reset) begin
            e_seg  = 7'b1111111;
            e_en   = 4'hF;
            e_tick = 1'b0;
            k      = 0;
            m_pend = 16'hFFFF;
            m_act  = 16'hFFFF;
        end else begin
            mp     = k % F;
            md     = mp / SD;
            e_tick = (mp == F - 1);
            if (mp % SD == 0) begin
                e_seg = 7'b1111111;
                e_en  = 4'hF;
            end else begin
                e_en  = 4'hF & ~(4'b0001 << md);
                e_seg = (blank_lz && lz_off(m_act, md)) ? 7'b1111111 : glyph(m_act[4*md +: 4]);
            end
            if (load) m_pend = codes;
            if (mp == F - 1) m_act = m_pend;
            k++;
        end
        m_valid = 1'b1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_seg", 32'(seg), 32'(e_seg));
            check("model_dig_en", 32'(dig_en), 32'(e_en));
            check("model_tick", 32'(frame_tick), 32'(e_tick));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 64);
        if (frame_tick !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_tick: frame_tick never seen within 64 cycles");
        end
    endtask

    task automatic seek(input int d, input logic [0:6] exp_seg, input string name);
        int n = 0;
        logic [3:0] tgt;
        tgt = 4'hF & ~(4'b0001 << d);
        while (dig_en !== tgt && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (dig_en !== tgt) begin
            tests++;
            fails++;
            $display("FAIL %s: digit %0d never enabled, dig_en=%b", name, d, dig_en);
        end else begin
            check(name, 32'(seg), 32'(exp_seg));
        end
    endtask

    task automatic do_load(input logic [15:0] c);
        load  = 1'b1;
        codes = c;
        @(negedge clk);
        load  = 1'b0;
    endtask

    logic [3:0] seq [8] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
    int tcnt;

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        codes    = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dig_en", 32'(dig_en), 32'hF);
        check("reset_tick", 32'(frame_tick), 32'h0);

        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("scan_seq", 32'(dig_en), 32'(seq[i]));
        end

        tcnt = 0;
        repeat (32) begin
            @(negedge clk);
            if (frame_tick) tcnt++;
        end
        check("tick_count", 32'(tcnt), 32'd2);

        repeat (5) @(negedge clk);
        do_load(16'h1234);
        wait_tick();
        seek(0, 7'b1001100, "d0_4");
        seek(1, 7'b0000110, "d1_3");
        seek(2, 7'b0010010, "d2_2");
        seek(3, 7'b1001111, "d3_1");

        blank_lz = 1'b1;
        do_load(16'h0050);
        wait_tick();
        seek(0, 7'b0000001, "lz_d0_0");
        seek(1, 7'b0100100, "lz_d1_5");
        seek(2, 7'b1111111, "lz_d2_blank");
        seek(3, 7'b1111111, "lz_d3_blank");

        do_load(16'h0000);
        wait_tick();
        seek(0, 7'b0000001, "zero_d0");
        seek(1, 7'b1111111, "zero_d1_blank");

        blank_lz = 1'b0;
        do_load(16'hBAF9);
        wait_tick();
        seek(0, 7'b0001100, "sym_d0_9");
        seek(1, 7'b1111111, "sym_d1_blank");
        seek(2, 7'b1111010, "sym_d2_r");
        seek(3, 7'b1111110, "sym_d3_dash");

        wait_tick();
        repeat (F - 1) @(negedge clk);
        do_load(16'h5678);
        check("wrap_tick", 32'(frame_tick), 32'h1);
        seek(0, 7'b0000000, "wrap_d0_8");
        seek(1, 7'b0001111, "wrap_d1_7");

        reset = 1'b1;
        @(negedge clk);
        check("midreset_seg", 32'(seg), 32'h7F);
        check("midreset_dig_en", 32'(dig_en), 32'hF);
        check("midreset_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_dead", 32'(dig_en), 32'hF);
        @(negedge clk);
        check("post_reset_d0_en", 32'(dig_en), 32'hE);
        check("post_reset_d0_blank", 32'(seg), 32'h7F);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
